// File: rtl/speed_ctrl_pkg.sv
// speed_ctrl_pkg: state encoding, control bit positions and default address map for speed_ctrl
package speed_ctrl_pkg;
  typedef enum logic [3:0] {
    SLOW     = 4'b0001,
    FAST_REQ = 4'b0010,
    FAST     = 4'b0100,
    SLOW_REQ = 4'b1000
  } state_t;
  localparam int CTRL_DIV_LSB    = 0;
  localparam int CTRL_DIV_MSB    = 1;
  localparam int CTRL_FORCE_SLOW = 2;
  localparam logic [15:0] IO_BASE_DEF   = 16'hFC00;
  localparam logic [15:0] IO_TOP_DEF    = 16'hFEFF;
  localparam logic [15:0] CTRL_ADDR_DEF = 16'hFE90;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-flop synchroniser for one asynchronous level input
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/speed_ctrl.sv
// speed_ctrl: address-driven fast/slow CPU clock request with stall; SPEED_CTRL_TIMEOUT_EN adds an acknowledge timeout
module speed_ctrl
  import speed_ctrl_pkg::*;
#(
  parameter logic [15:0] IO_BASE        = IO_BASE_DEF,
  parameter logic [15:0] IO_TOP         = IO_TOP_DEF,
  parameter logic [15:0] CTRL_ADDR      = CTRL_ADDR_DEF,
  parameter int          DWELL_CYCLES   = 4,
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        hsclk_in,
  input  logic        rst,
  input  logic        cyc_valid,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_data,
  input  logic        hsclk_selected,
  input  logic        lsclk_selected,
  output logic        hsclk_sel,
  output logic [1:0]  cpuclk_div_sel,
  output logic        cpu_rdy,
  output logic [7:0]  ctrl_q,
  output logic        switch_err
);
  state_t state, nxt;
  logic hs_ack, ls_ack, cv, slow_hit, wr, go_fast, go_slow, tmo;
  logic [3:0] dwell, dwell_nxt;
  logic [7:0] ctrl_nxt;
  sync_bit #(.STAGES(SYNC_STAGES)) u_hs (.clk(hsclk_in), .rst(rst), .d(hsclk_selected), .q(hs_ack));
  sync_bit #(.STAGES(SYNC_STAGES)) u_ls (.clk(hsclk_in), .rst(rst), .d(lsclk_selected), .q(ls_ack));
  // cycles presented while stalled are the CPU holding its bus, not new cycles
  assign cv       = cyc_valid & cpu_rdy;
  assign slow_hit = cv & ((cpu_addr >= IO_BASE && cpu_addr <= IO_TOP) | ctrl_q[CTRL_FORCE_SLOW]);
  assign wr       = cv & ~cpu_rnw & (cpu_addr == CTRL_ADDR);
  assign go_fast  = hs_ack & ~ls_ack;
  assign go_slow  = ls_ack & ~hs_ack;
  assign ctrl_nxt = (wr ? cpu_data : ctrl_q) | {5'b0, tmo, 2'b0};
`ifdef SPEED_CTRL_TIMEOUT_EN
  logic [7:0] tcnt;
  logic req;
  assign req = state == FAST_REQ || state == SLOW_REQ;
  assign tmo = req && tcnt == 8'(TIMEOUT_CYCLES) && !(state == FAST_REQ ? go_fast : go_slow);
  always_ff @(posedge hsclk_in or posedge rst)
    if (rst) begin
      tcnt       <= '0;
      switch_err <= 1'b0;
    end else begin
      tcnt       <= (req && nxt == state) ? tcnt + 8'd1 : 8'd0;
      switch_err <= switch_err | tmo;
    end
`else
  assign tmo        = 1'b0;
  assign switch_err = 1'b0;
`endif
  always_comb begin
    nxt       = state;
    dwell_nxt = dwell;
    case (state)
      SLOW:
        if (slow_hit) dwell_nxt = '0;
        else if (cv) begin
          dwell_nxt = (dwell == 4'(DWELL_CYCLES - 1)) ? 4'd0 : dwell + 4'd1;
          nxt       = (dwell == 4'(DWELL_CYCLES - 1)) ? FAST_REQ : SLOW;
        end
      FAST_REQ: nxt = go_fast ? FAST : tmo ? SLOW : FAST_REQ;
      FAST:     nxt = slow_hit ? SLOW_REQ : FAST;
      SLOW_REQ: nxt = (go_slow || tmo) ? SLOW : SLOW_REQ;
      default:  nxt = SLOW;
    endcase
  end
  always_ff @(posedge hsclk_in or posedge rst)
    if (rst) begin
      state          <= SLOW;
      dwell          <= '0;
      hsclk_sel      <= 1'b0;
      cpu_rdy        <= 1'b1;
      ctrl_q         <= '0;
      cpuclk_div_sel <= '0;
    end else begin
      state     <= nxt;
      dwell     <= dwell_nxt;
      hsclk_sel <= nxt == FAST_REQ || nxt == FAST;
      cpu_rdy   <= nxt == SLOW || nxt == FAST;
      ctrl_q    <= ctrl_nxt;
      if (state == SLOW) cpuclk_div_sel <= ctrl_q[CTRL_DIV_MSB:CTRL_DIV_LSB];
    end
endmodule
